cla8_sub_pipe: RTL and testbench
================================

Name: cla8_sub_pipe

Overview:
- 2-stage pipelined 8-bit subtractor: Diff = A - B - borrowIn.
- Built from two 4-bit carry-lookahead nibble slices, one slice per pipeline stage, using two's-complement addition: A + ~B + ~borrowIn.
- Inverse-direction companion to the team's 8-bit CLA adder, for datapaths that need registered, flow-controlled subtraction.
- valid/ready handshake on input and output; sustains 1 result/cycle.

Parameters:
- WIDTH, 8, operand width; must be even; the low half is resolved in stage 1, the high half in stage 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inValid  input  1  operand beat present on A/B/borrowIn
- inReady  output  1  block can accept an operand beat this cycle
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- borrowIn  input  1  borrow in (1 = subtract one more)
- outValid  output  1  result present on Diff/borrowOut/overflow
- outReady  input  1  downstream accepts the result this cycle
- Diff  output  WIDTH  (A - B - borrowIn) mod 2^WIDTH
- borrowOut  output  1  1 when unsigned A < B + borrowIn
- overflow  output  1  signed two's-complement overflow of the subtraction

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low. While rst_n = 0, all stage valids = 0, outValid = 0, Diff = 0, borrowOut = 0, overflow = 0; inReady = 1 once out of reset.
- Arithmetic: Bn = ~B, cin = ~borrowIn.
  - Each nibble computes p = a ^ bn and g = a & bn, then carries via CLA equations (no ripple).
  - borrowOut = ~carryOut of the MSB.
  - overflow = (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]).
- Stage 1 (on accept, inValid && inReady):
  - compute the low nibble sum and its carry-out c_mid;
  - register s1Valid = 1, the low diff, c_mid, A high half, Bn high half, and A[MSB]/B[MSB].
- Stage 2:
  - compute the high nibble from the s1 registers with c_mid as carry-in;
  - register Diff = {high, low}, borrowOut, overflow, outValid = 1.
- Advance rules:
  - s2 loads when s1Valid && (!outValid || outReady).
  - s1 loads when inValid && inReady.
  - inReady = !s1Valid || !outValid || outReady (combinational, no dependence on inValid).
- Latency: 2 cycles. A beat accepted at edge N appears with outValid = 1 after edge N+1, when the output stage is free.
- Output hold: while outValid && !outReady, Diff/borrowOut/overflow/outValid hold stable; s1 holds its beat.
- Drain: an output transfer (outValid && outReady) with no s1 beat to advance clears outValid to 0 on that edge.
- Full pipeline: with s1Valid && outValid && !outReady, inReady = 0 and inputs are ignored.
- Simultaneous events: output transfer, s1->s2 move and new accept can all happen on one edge; no bubble, order preserved.
- Reset mid-operation: all in-flight beats are discarded, nothing emitted; the first post-reset accept behaves as from reset.
- Combinational path: no path from inValid/A/B to outputs. The only comb path is outReady -> inReady.

Test Plan:
- Basic: outReady = 1; A=0x01, B=0x01, borrowIn=0 accepted at cycle 0 -> cycle 2: outValid=1, Diff=0x00, borrowOut=0, overflow=0.
- Borrow: A=0x1B, B=0xD7, borrowIn=0 -> Diff=0x44, borrowOut=1, overflow=0.
- Borrow-in + overflow: A=0x7B, B=0xD3, borrowIn=1 -> Diff=0xA7, borrowOut=1, overflow=1. Then A=0x80, B=0x01, borrowIn=0 -> Diff=0x7F, borrowOut=0, overflow=1.
- Streaming: 4 back-to-back beats (0x10-0x01, 0x00-0x01, 0xFF-0xFF, 0x05-0x03) with outReady = 1.
  - Required: results 0x0F/b0, 0xFF/b1, 0x00/b0, 0x02/b0 on 4 consecutive cycles starting 2 cycles after the first accept; inReady stays 1.
- Backpressure: outReady = 0 while 3 beats are offered.
  - Required: 2 beats accepted, then inReady = 0; Diff held stable.
  - On release, results appear in order; the third beat is accepted on the release cycle; no duplicates or drops.
- Reset mid-op: assert rst_n = 0 asynchronously between clock edges with 2 beats in flight.
  - Required: outValid/Diff/borrowOut/overflow = 0 immediately; no stale result after release; the next beat A=0x05, B=0x03 gives 0x02.

Source files
------------

// File: rtl/cla8_sub_pipe_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
// The slave side is the subtractor itself; the master side is the surrounding datapath.
interface cla8_sub_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             borrowIn;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] Diff;
    logic             borrowOut;
    logic             overflow;

    modport slave (
        input  inValid, A, B, borrowIn, outReady,
        output inReady, outValid, Diff, borrowOut, overflow
    );

    modport master (
        output inValid, A, B, borrowIn, outReady,
        input  inReady, outValid, Diff, borrowOut, overflow
    );
endinterface

// File: rtl/cla8_sub_pipe.sv
// Two-stage flow-controlled subtractor: A - B - borrowIn computed as A + ~B + ~borrowIn,
// low half resolved by a carry-lookahead slice in stage 1, high half in stage 2.
module cla8_sub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cla8_sub_pipe_if.slave   bus
);
    localparam int H = WIDTH / 2;

    // Flattened lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
    function automatic logic [H:0] cla_half(
        input logic [H-1:0] a,
        input logic [H-1:0] bn,
        input logic         cin
    );
        logic [H-1:0] p;
        logic [H-1:0] g;
        logic [H:0]   c;
        logic         acc;
        logic         prod;
        p    = a ^ bn;
        g    = a & bn;
        c    = {(H+1){1'b0}};
        c[0] = cin;
        for (int i = 0; i < H; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            acc    = acc | (prod & cin);
            c[i+1] = acc;
        end
        return {c[H], p ^ c[H-1:0]};
    endfunction

    logic             in_ready_s;
    logic             accept_s;
    logic             advance_s;
    logic [H:0]       lo_res_s;
    logic [H:0]       hi_res_s;
    logic [WIDTH-1:0] bn_s;
    logic             ovf_s;

    logic             s1_valid_d,  s1_valid_q;
    logic [H-1:0]     s1_lo_d,     s1_lo_q;
    logic             s1_cmid_d,   s1_cmid_q;
    logic [H-1:0]     s1_a_hi_d,   s1_a_hi_q;
    logic [H-1:0]     s1_bn_hi_d,  s1_bn_hi_q;
    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] diff_d,      diff_q;
    logic             borrow_d,    borrow_q;
    logic             ovf_d,       ovf_q;

    // Handshake decode and both arithmetic slices; outReady -> inReady is the only comb path.
    always_comb begin
        in_ready_s = !s1_valid_q || !out_valid_q || bus.outReady;
        accept_s   = bus.inValid && in_ready_s;
        advance_s  = s1_valid_q && (!out_valid_q || bus.outReady);
        bn_s       = ~bus.B;
        lo_res_s   = cla_half(bus.A[H-1:0], bn_s[H-1:0], ~bus.borrowIn);
        hi_res_s   = cla_half(s1_a_hi_q, s1_bn_hi_q, s1_cmid_q);
        // Operands differ in sign and the result sign departs from the minuend.
        ovf_s      = (s1_a_hi_q[H-1] != ~s1_bn_hi_q[H-1]) && (hi_res_s[H-1] != s1_a_hi_q[H-1]);
    end

    // Next-state for both pipeline stages; everything holds unless a move happens.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_lo_d     = s1_lo_q;
        s1_cmid_d   = s1_cmid_q;
        s1_a_hi_d   = s1_a_hi_q;
        s1_bn_hi_d  = s1_bn_hi_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;

        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_lo_d    = lo_res_s[H-1:0];
            s1_cmid_d  = lo_res_s[H];
            s1_a_hi_d  = bus.A[WIDTH-1:H];
            s1_bn_hi_d = bn_s[WIDTH-1:H];
        end else if (advance_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (advance_s) begin
            out_valid_d = 1'b1;
            diff_d      = {hi_res_s[H-1:0], s1_lo_q};
            borrow_d    = ~hi_res_s[H];
            ovf_d       = ovf_s;
        end else if (out_valid_q && bus.outReady) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; reset discards any in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= {H{1'b0}};
            s1_cmid_q   <= 1'b0;
            s1_a_hi_q   <= {H{1'b0}};
            s1_bn_hi_q  <= {H{1'b0}};
            out_valid_q <= 1'b0;
            diff_q      <= {WIDTH{1'b0}};
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_cmid_q   <= s1_cmid_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_bn_hi_q  <= s1_bn_hi_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.inReady   = in_ready_s;
    assign bus.outValid  = out_valid_q;
    assign bus.Diff      = diff_q;
    assign bus.borrowOut = borrow_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cla8_sub_pipe.sv
// Scoreboard bench for cla8_sub_pipe: directed beats push hand-computed results,
// an independent monitor pops and compares on every output transfer.
module tb_cla8_sub_pipe;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    typedef struct packed {
        logic [7:0] diff;
        logic       bo;
        logic       ovf;
        logic       lat;
        int         acc_cyc;
    } exp_t;

    exp_t exp_q[$];

    cla8_sub_pipe_if #(.WIDTH(8)) bus ();

    cla8_sub_pipe #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Offer one beat until accepted; pushes the expectation at the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic ebo, input logic eovf,
                        input logic lat, output int tries);
        exp_t e;
        bit   done;
        done  = 1'b0;
        tries = 0;
        while (!done && tries < 50) begin
            @(negedge clk);
            bus.inValid  = 1'b1;
            bus.A        = a;
            bus.B        = b;
            bus.borrowIn = bin;
            #1;
            tries++;
            if (bus.inReady === 1'b1) begin
                e.diff = ed; e.bo = ebo; e.ovf = eovf; e.lat = lat; e.acc_cyc = cyc;
                exp_q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.inValid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    // Monitor: compares each transfer and checks stability while stalled.
    logic       hold_r;
    logic [7:0] hold_diff;
    logic       hold_bo;
    logic       hold_ovf;
    initial begin
        exp_t e;
        hold_r = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                hold_r = 1'b0;
            end else begin
                if (hold_r) begin
                    chk("hold_valid", bus.outValid, 32'd1);
                    chk("hold_diff", bus.Diff, hold_diff);
                    chk("hold_flags", {bus.borrowOut, bus.overflow}, {hold_bo, hold_ovf});
                end
                hold_r = 1'b0;
                if (bus.outValid === 1'b1) begin
                    if (bus.outReady === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_out", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("diff", bus.Diff, e.diff);
                            chk("borrowOut", bus.borrowOut, e.bo);
                            chk("overflow", bus.overflow, e.ovf);
                            if (e.lat) chk("latency", cyc, e.acc_cyc + 2);
                        end
                    end else begin
                        hold_r    = 1'b1;
                        hold_diff = bus.Diff;
                        hold_bo   = bus.borrowOut;
                        hold_ovf  = bus.overflow;
                    end
                end
            end
        end
    end

    initial begin
        int t;
        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0;
        bus.inValid = 1'b0; bus.A = 8'h00; bus.B = 8'h00; bus.borrowIn = 1'b0;
        bus.outReady = 1'b1;
        #12;
        chk("rst_outValid", bus.outValid, 32'd0);
        chk("rst_diff", bus.Diff, 32'd0);
        chk("rst_flags", {bus.borrowOut, bus.overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_inReady", bus.inReady, 32'd1);

        // Basic, borrow, borrow-in with overflow, negative overflow
        send(8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, t);
        idle(3);
        send(8'h1B, 8'hD7, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, t);
        idle(3);
        send(8'h7B, 8'hD3, 1'b1, 8'hA7, 1'b1, 1'b1, 1'b1, t);
        idle(3);
        send(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1, t);
        idle(3);
        wait_drain();

        // Streaming: one accept per cycle, results at fixed latency
        send(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, t);
        chk("stream_inready0", t, 32'd1);
        send(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, t);
        chk("stream_inready1", t, 32'd1);
        send(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, t);
        chk("stream_inready2", t, 32'd1);
        send(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, t);
        chk("stream_inready3", t, 32'd1);
        idle(1);
        wait_drain();
        #1;
        chk("drain_outValid", bus.outValid, 32'd0);

        // Backpressure: two beats fill the pipe, the third waits for release
        @(negedge clk);
        bus.outReady = 1'b0;
        send(8'h30, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, t);
        send(8'h44, 8'h04, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0, t);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.A = 8'h09; bus.B = 8'h0A; bus.borrowIn = 1'b0; bus.inValid = 1'b1;
            #1;
            chk("bp_inReady_low", bus.inReady, 32'd0);
        end
        @(negedge clk);
        bus.outReady = 1'b1;
        #1;
        chk("bp_release_accept", bus.inReady, 32'd1);
        begin
            exp_t e;
            e.diff = 8'hFF; e.bo = 1'b1; e.ovf = 1'b0; e.lat = 1'b0; e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        idle(1);
        wait_drain();

        // Reset with two beats in flight
        @(negedge clk);
        bus.outReady = 1'b0;
        send(8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, t);
        send(8'h66, 8'h22, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, t);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.inValid = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_outValid", bus.outValid, 32'd0);
        chk("midrst_diff", bus.Diff, 32'd0);
        chk("midrst_flags", {bus.borrowOut, bus.overflow}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        bus.outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("postrst_no_stale", bus.outValid, 32'd0);
        end
        send(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, t);
        idle(1);
        wait_drain();
        idle(2);
        #1;
        chk("final_outValid", bus.outValid, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
